expr_pipe_lanes: RTL and testbench
==================================

Name: expr_pipe_lanes

Overview:
- Parametrised, pipelined successor to the flat combinational mixed-signedness expression blocks.
- Evaluates one selectable operation on LANES independent W-bit operand pairs.
- Operand signedness is runtime-controlled and follows Verilog expression semantics.
- Results pass through an elastic valid/ready pipeline of STAGES registers; the block sits as a regression/datapath unit between stimulus and checker stages.

Parameters:
- W, 6, lane operand/result width (2..32)
- LANES, 3, number of parallel lanes (1..8)
- STAGES, 2, pipeline register stages (1..4)

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input beat valid
- in_ready  output  1  block can accept beat
- op  input  4  operation select (captured with beat)
- a_signed  input  1  treat all a lanes as signed
- b_signed  input  1  treat all b lanes as signed
- a  input  LANES*W  lane i at [i*W +: W]
- b  input  LANES*W  lane i at [i*W +: W]
- out_valid  output  1  result beat valid
- out_ready  input  1  downstream accepts beat
- y  output  LANES*W  lane results, same packing as a
- ovf  output  LANES  per-lane overflow flag (see Optional Feature)

Behaviour:
- Reset (async assert, sync release): all stage valids 0; out_valid=0; y=0; ovf=0; in_ready=1 after release.
- Handshake: beat accepted when in_valid&&in_ready; beat leaves when out_valid&&out_ready.
- Stage k advances when stage k+1 is empty or advancing. in_ready = !v0 || stage 0 advancing (combinational from out_ready through the chain).
- Latency = STAGES cycles from acceptance to out_valid with out_ready high; throughput 1 beat/cycle.
- No drop, no duplication, strict order. y/ovf hold stable while out_valid && !out_ready.
- Operation is computed in stage 0; op, a_signed and b_signed are sampled with the beat.
- Signedness rule: context is signed only if a_signed && b_signed; otherwise both operands are zero-extended. Results are truncated to W.
- op codes:
  - 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 xnor
  - 6 shl (logical), 7 shr (logical)
  - 8 ashr: fills with a's MSB iff a_signed; b is always an unsigned shift amount
  - 9 lt, 10 eq, 11 ne: 1-bit result zero-extended to W
  - 12 mul, truncated to the low W bits
  - 13 div, 14 mod
  - 15 sel: (|a) ? a : b
- Shifts: amount >= W gives 0, or all-sign for signed ashr.
- Divide by zero: div returns all ones; mod returns a. Signed div truncates toward zero; signed mod takes the sign of a. Signed min / -1: div returns min, mod returns 0.
- Reset mid-operation: in-flight beats discarded; out_valid drops in the same cycle rst_n falls.

Optional Feature:
- Macro: EXPR_PIPE_SAT_EN.
- Defined:
  - add, sub and mul saturate to the W-bit range of the active context (signed: -2^(W-1)..2^(W-1)-1; unsigned: 0..2^W-1).
  - ovf[i] = 1 when lane i clamped, for that beat only.
- Undefined: all ops wrap; ovf is tied to 0.

Test Plan (W=6, LANES=3, STAGES=2):
- Add wrap: lane0 a=40, b=30, op=0, out_ready=1, accept at cycle 0 -> out_valid at cycle 2, y lane0=6; with EXPR_PIPE_SAT_EN -> y=63, ovf[0]=1.
- Ashr: a=6'b100000, b=2, op=8 -> y=6'b111000 when a_signed=1; 6'b001000 when a_signed=0.
- Mixed compare: a=6'h3F, b=1, op=9 -> a_signed=1, b_signed=0 gives 0 (unsigned 63<1); both signed gives 1 (-1<1).
- Divide by zero: a=17, b=0 -> op=13 gives 6'h3F; op=14 gives 17. Signed -32 / -1 -> -32.
- Backpressure: stream 6 back-to-back beats with out_ready=0 for cycles 0..7 -> exactly 2 beats accepted, in_ready=0 thereafter; after release all 6 emerge in order, unchanged, one per cycle.
- Reset mid-stream: 2 beats in flight, pull rst_n low -> out_valid=0 and y=0 immediately; after release the first new beat appears 2 cycles after acceptance.

Source files
------------

// File: rtl/expr_pipe_lanes.sv
// Multi-lane mixed-signedness expression unit behind an elastic valid/ready pipeline.
// Optional saturation of add/sub/mul (with per-lane ovf) is enabled by defining EXPR_PIPE_SAT_EN.
module expr_pipe_lanes #(
    parameter int W      = 6,
    parameter int LANES  = 3,
    parameter int STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           op,
    input  logic                 a_signed,
    input  logic                 b_signed,
    input  logic [LANES*W-1:0]   a,
    input  logic [LANES*W-1:0]   b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*W-1:0]   y,
    output logic [LANES-1:0]     ovf
);

    // Handshake: a beat moves on a clock edge only when its valid and the
    // receiver's ready are both high; a stalled stage holds valid and data.

    localparam logic [W-1:0] W_L = W'(W);

`ifdef EXPR_PIPE_SAT_EN
    localparam logic [2*W-1:0] SMAX = {{(W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic [2*W-1:0] SMIN = {{(W+1){1'b1}}, {(W-1){1'b0}}};
    localparam logic [2*W-1:0] UMAX = {{W{1'b0}}, {W{1'b1}}};

    // Clamp an exact double-width result into the W-bit range of the context.
    function automatic logic [W:0] clamp(input logic sc, input logic [2*W-1:0] v);
        if (sc) begin
            if ($signed(v) > $signed(SMAX)) return {1'b1, SMAX[W-1:0]};
            if ($signed(v) < $signed(SMIN)) return {1'b1, SMIN[W-1:0]};
        end else if (v > UMAX) begin
            return {1'b1, UMAX[W-1:0]};
        end
        return {1'b0, v[W-1:0]};
    endfunction
`endif

    // One lane: returns {overflow, result}.
    function automatic logic [W:0] lane_op(
        input logic [3:0]   o,
        input logic         sa,
        input logic         sb,
        input logic [W-1:0] la,
        input logic [W-1:0] lb
    );
        logic           sc;
        logic [2*W-1:0] ax;
        logic [2*W-1:0] bx;
        logic [W-1:0]   r;
        logic           of;
`ifdef EXPR_PIPE_SAT_EN
        logic [W:0]     c;
`endif
        sc = sa && sb;
        ax = sc ? {{W{la[W-1]}}, la} : {{W{1'b0}}, la};
        bx = sc ? {{W{lb[W-1]}}, lb} : {{W{1'b0}}, lb};
        r  = '0;
        of = 1'b0;
`ifdef EXPR_PIPE_SAT_EN
        c  = '0;
`endif
        case (o)
            4'd0: begin
`ifdef EXPR_PIPE_SAT_EN
                c  = clamp(sc, ax + bx);
                r  = c[W-1:0];
                of = c[W];
`else
                r = la + lb;
`endif
            end
            4'd1: begin
`ifdef EXPR_PIPE_SAT_EN
                if (!sc && (la < lb)) begin
                    r  = '0;
                    of = 1'b1;
                end else begin
                    c  = clamp(sc, ax - bx);
                    r  = c[W-1:0];
                    of = c[W];
                end
`else
                r = la - lb;
`endif
            end
            4'd2:  r = la & lb;
            4'd3:  r = la | lb;
            4'd4:  r = la ^ lb;
            4'd5:  r = ~(la ^ lb);
            4'd6:  r = (lb >= W_L) ? '0 : (la << lb);
            4'd7:  r = (lb >= W_L) ? '0 : (la >> lb);
            4'd8: begin
                // Fill follows a's own signedness; b is always a plain amount.
                if (sa) begin
                    if (lb >= W_L) r = {W{la[W-1]}};
                    else           r = $signed(la) >>> lb;
                end else begin
                    r = (lb >= W_L) ? '0 : (la >> lb);
                end
            end
            4'd9:  r = {{(W-1){1'b0}}, (sc ? ($signed(la) < $signed(lb)) : (la < lb))};
            4'd10: r = {{(W-1){1'b0}}, (la == lb)};
            4'd11: r = {{(W-1){1'b0}}, (la != lb)};
            4'd12: begin
`ifdef EXPR_PIPE_SAT_EN
                c  = clamp(sc, ax * bx);
                r  = c[W-1:0];
                of = c[W];
`else
                r = la * lb;
`endif
            end
            4'd13: begin
                // Double-width signed divide makes min / -1 land on min after truncation.
                if (lb == '0)   r = '1;
                else if (sc)    r = W'($signed(ax) / $signed(bx));
                else            r = la / lb;
            end
            4'd14: begin
                if (lb == '0)   r = la;
                else if (sc)    r = W'($signed(ax) % $signed(bx));
                else            r = la % lb;
            end
            default: r = (|la) ? la : lb;
        endcase
        return {of, r};
    endfunction

    logic [STAGES-1:0]  v;
    logic [STAGES-1:0]  rdy;
    logic [LANES*W-1:0] yd [STAGES];
    logic [LANES-1:0]   od [STAGES];
    logic [LANES*W-1:0] y_c;
    logic [LANES-1:0]   o_c;
    logic [W:0]         lane_res;

    always_comb begin
        y_c      = '0;
        o_c      = '0;
        lane_res = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_res         = lane_op(op, a_signed, b_signed, a[i*W +: W], b[i*W +: W]);
            y_c[i*W +: W]    = lane_res[W-1:0];
            o_c[i]           = lane_res[W];
        end
    end

    // A stage can take a beat when it is empty or its occupant is moving on.
    always_comb begin
        logic go;
        rdy = '0;
        go  = !v[STAGES-1] || out_ready;
        rdy[STAGES-1] = go;
        for (int k = STAGES - 2; k >= 0; k--) begin
            go     = !v[k] || go;
            rdy[k] = go;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            for (int k = 0; k < STAGES; k++) begin
                yd[k] <= '0;
                od[k] <= '0;
            end
        end else begin
            if (rdy[0]) begin
                v[0] <= in_valid;
                if (in_valid) begin
                    yd[0] <= y_c;
                    od[0] <= o_c;
                end
            end
            for (int k = 1; k < STAGES; k++) begin
                if (rdy[k]) begin
                    v[k] <= v[k-1];
                    if (v[k-1]) begin
                        yd[k] <= yd[k-1];
                        od[k] <= od[k-1];
                    end
                end
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = v[STAGES-1];
    assign y         = yd[STAGES-1];
    assign ovf       = od[STAGES-1];

endmodule

// File: tb/tb_expr_pipe_lanes.sv
// Scoreboard bench for expr_pipe_lanes: directed corner beats, backpressure, reset, random traffic.
module tb_expr_pipe_lanes;

    localparam int W      = 6;
    localparam int LANES  = 3;
    localparam int STAGES = 2;
    localparam int EW     = LANES * W + LANES;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [3:0]         op;
    logic               a_signed;
    logic               b_signed;
    logic [LANES*W-1:0] a;
    logic [LANES*W-1:0] b;
    logic               out_valid;
    logic               out_ready;
    logic [LANES*W-1:0] y;
    logic [LANES-1:0]   ovf;

    expr_pipe_lanes #(.W(W), .LANES(LANES), .STAGES(STAGES)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a_signed(a_signed), .b_signed(b_signed),
        .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .ovf(ovf)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int errors = 0;
    int checks = 0;
    int acc_cnt = 0;
    int out_cnt = 0;
    int last_acc_cyc = 0;
    bit rand_ready = 0;
    logic [EW-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // reference model: plain integer arithmetic per lane, returns {ovf, result}
    function automatic logic [W:0] ref_lane(input int o, input bit sa, input bit sb, input int ua, input int ub);
        int     mask, sav, sbv, av, bv, lo, hi, r;
        longint t;
        bit     sc, of;
        mask = (1 << W) - 1;
        sc   = sa && sb;
        sav  = (ua >= (1 << (W-1))) ? ua - (1 << W) : ua;
        sbv  = (ub >= (1 << (W-1))) ? ub - (1 << W) : ub;
        av   = sc ? sav : ua;
        bv   = sc ? sbv : ub;
        lo   = sc ? -(1 << (W-1)) : 0;
        hi   = sc ? (1 << (W-1)) - 1 : mask;
        of   = 0;
        r    = 0;
        case (o)
            0, 1, 12: begin
                if (o == 0)      t = longint'(av) + bv;
                else if (o == 1) t = longint'(av) - bv;
                else             t = longint'(av) * bv;
`ifdef EXPR_PIPE_SAT_EN
                if (t > hi)      begin t = hi; of = 1; end
                else if (t < lo) begin t = lo; of = 1; end
`endif
                r = int'(t & mask);
            end
            2:  r = ua & ub;
            3:  r = ua | ub;
            4:  r = ua ^ ub;
            5:  r = ~(ua ^ ub) & mask;
            6:  r = (ub >= W) ? 0 : ((ua << ub) & mask);
            7:  r = (ub >= W) ? 0 : (ua >> ub);
            8: begin
                if (!sa)          r = (ub >= W) ? 0 : (ua >> ub);
                else if (ub >= W) r = (sav < 0) ? mask : 0;
                else              r = (sav >>> ub) & mask;
            end
            9:  r = (av < bv) ? 1 : 0;
            10: r = (ua == ub) ? 1 : 0;
            11: r = (ua != ub) ? 1 : 0;
            13: r = (ub == 0) ? mask : ((av / bv) & mask);
            14: r = (ub == 0) ? ua : ((av % bv) & mask);
            default: r = (ua != 0) ? ua : ub;
        endcase
        return {of, r[W-1:0]};
    endfunction

    function automatic logic [LANES*W-1:0] rep(input logic [W-1:0] x);
        return {LANES{x}};
    endfunction

    function automatic logic [EW-1:0] exp0(input logic [W-1:0] x);
        return {{LANES{1'b0}}, rep(x)};
    endfunction

    // driver tasks: called at posedge+1, return at posedge+1 after acceptance
    task automatic send(input logic [3:0] o, input logic sa, input logic sb,
                        input logic [LANES*W-1:0] av, input logic [LANES*W-1:0] bv,
                        input logic [EW-1:0] e);
        int n;
        n = 0;
        in_valid = 1'b1;
        op = o; a_signed = sa; b_signed = sb; a = av; b = bv;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 500);
        if (in_ready) begin
            exp_q.push_back(e);
            acc_cnt++;
            last_acc_cyc = cyc;
        end else begin
            errors++;
            checks++;
            $display("FAIL accept timeout: actual=in_ready_low required=accept");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_model(input logic [3:0] o, input logic sa, input logic sb,
                              input logic [LANES*W-1:0] av, input logic [LANES*W-1:0] bv);
        logic [EW-1:0] e;
        logic [W:0]    l;
        e = '0;
        for (int i = 0; i < LANES; i++) begin
            l = ref_lane(int'(o), sa, sb, int'(av[i*W +: W]), int'(bv[i*W +: W]));
            e[i*W +: W]     = l[W-1:0];
            e[LANES*W + i]  = l[W];
        end
        send(o, sa, sb, av, bv, e);
    endtask

    task automatic send_random();
        logic [LANES*W-1:0] av, bv;
        for (int i = 0; i < LANES; i++) begin
            av[i*W +: W] = ($urandom_range(0, 4) == 0) ? W'(1 << (W-1)) : W'($urandom);
            case ($urandom_range(0, 3))
                0:       bv[i*W +: W] = W'($urandom_range(0, W + 1));
                1:       bv[i*W +: W] = ($urandom_range(0, 1) == 0) ? '0 : '1;
                default: bv[i*W +: W] = W'($urandom);
            endcase
        end
        send_model(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), av, bv);
    endtask

    task automatic lat_check(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        check(name, 64'(cyc - last_acc_cyc), 64'(STAGES));
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int target);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || acc_cnt < target) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || acc_cnt < target) begin
            errors++;
            $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    // downstream readiness during random traffic
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // scoreboard monitor
    bit            stalled = 0;
    logic [EW-1:0] held;
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 0;
        end else begin
            if (stalled) check("hold", {out_valid, ovf, y}, {1'b1, held});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL unexpected beat: actual=%0h required=none", {ovf, y});
                end else begin
                    check("beat", {ovf, y}, exp_q.pop_front());
                end
                out_cnt++;
            end
            stalled = out_valid && !out_ready;
            held    = {ovf, y};
        end
    end

    logic [EW-1:0] e_add;
    int a0, o0;

    initial begin
`ifdef EXPR_PIPE_SAT_EN
        e_add = {{LANES{1'b1}}, rep(6'd63)};
`else
        e_add = exp0(6'd6);
`endif
        rst_n = 1'b0; in_valid = 1'b0; op = '0; a_signed = 1'b0; b_signed = 1'b0;
        a = '0; b = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset y", 64'(y), 64'd0);
        check("reset ovf", 64'(ovf), 64'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready after reset", 64'(in_ready), 64'd1);

        // add wrap/saturate and first-beat latency
        send(4'd0, 1'b0, 1'b0, rep(6'd40), rep(6'd30), e_add);
        lat_check("add latency");
        drain(acc_cnt);

        // directed corners, back to back
        send(4'd8,  1'b1, 1'b0, rep(6'b100000), rep(6'd2), exp0(6'b111000));
        send(4'd8,  1'b0, 1'b0, rep(6'b100000), rep(6'd2), exp0(6'b001000));
        send(4'd9,  1'b1, 1'b0, rep(6'h3F), rep(6'd1), exp0(6'd0));
        send(4'd9,  1'b1, 1'b1, rep(6'h3F), rep(6'd1), exp0(6'd1));
        send(4'd13, 1'b0, 1'b0, rep(6'd17), rep(6'd0), exp0(6'h3F));
        send(4'd14, 1'b0, 1'b0, rep(6'd17), rep(6'd0), exp0(6'd17));
        send(4'd13, 1'b1, 1'b1, rep(6'd32), rep(6'h3F), exp0(6'd32));
        send(4'd14, 1'b1, 1'b1, rep(6'd32), rep(6'h3F), exp0(6'd0));
        send(4'd13, 1'b0, 1'b0, rep(6'd50), rep(6'd7), exp0(6'd7));
        send(4'd6,  1'b0, 1'b0, rep(6'd5), rep(6'd6), exp0(6'd0));
        send(4'd8,  1'b1, 1'b0, rep(6'd40), rep(6'd7), exp0(6'h3F));
        send(4'd15, 1'b0, 1'b0, {6'd0, 6'd9, 6'd0}, {6'd4, 6'd5, 6'd6}, {3'b000, 6'd4, 6'd9, 6'd6});
`ifdef EXPR_PIPE_SAT_EN
        send(4'd12, 1'b0, 1'b0, rep(6'd9), rep(6'd9), {{LANES{1'b1}}, rep(6'd63)});
        send(4'd1,  1'b1, 1'b1, rep(6'd32), rep(6'd1), {{LANES{1'b1}}, rep(6'd32)});
        send(4'd1,  1'b0, 1'b0, rep(6'd3), rep(6'd5), {{LANES{1'b1}}, rep(6'd0)});
`else
        send(4'd12, 1'b0, 1'b0, rep(6'd9), rep(6'd9), exp0(6'd17));
        send(4'd1,  1'b1, 1'b1, rep(6'd32), rep(6'd1), exp0(6'd31));
        send(4'd1,  1'b0, 1'b0, rep(6'd3), rep(6'd5), exp0(6'd62));
`endif
        drain(acc_cnt);

        // backpressure: six beats against a stalled sink
        out_ready = 1'b0;
        a0 = acc_cnt;
        fork
            begin
                for (int i = 0; i < 6; i++) send_random();
            end
        join_none
        repeat (8) @(negedge clk);
        #1;
        check("bp accepted", 64'(acc_cnt - a0), 64'd2);
        check("bp in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        o0 = out_cnt;
        repeat (6) @(negedge clk);
        #1;
        check("bp one per cycle", 64'(out_cnt - o0), 64'd6);
        drain(a0 + 6);

        // reset with two beats in flight
        out_ready = 1'b0;
        send_random();
        send_random();
        rst_n = 1'b0;
        #1;
        check("midreset out_valid", 64'(out_valid), 64'd0);
        check("midreset y", 64'(y), 64'd0);
        check("midreset ovf", 64'(ovf), 64'd0);
        exp_q.delete();
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        check("in_ready after midreset", 64'(in_ready), 64'd1);
        send(4'd0, 1'b0, 1'b0, rep(6'd40), rep(6'd30), e_add);
        lat_check("post-reset latency");
        drain(acc_cnt);

        // random traffic with random sink stalls
        rand_ready = 1;
        for (int n = 0; n < 200; n++) begin
            send_random();
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        rand_ready = 0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain(acc_cnt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
